pll_lock_supervisor: RTL

//   Sequences the camera-clock PLL (50 MHz refclk -> 24 MHz XCLK) from the refclk domain.

---
 rtl/pll_lock_supervisor.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// Camera-clock PLL sequencer: pulses the PLL reset, qualifies lock stability,
// releases the consumer-domain reset, and retries or faults on lock trouble.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 4,
  parameter int CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       domain_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state
);

  localparam int RETRY_W = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [RETRY_W-1:0]  retry_r;
  logic [RETRY_W-1:0]  retry_inc_s;
  logic                meta_r;
  logic                lock_r;
  logic                lock_s;

  // Output levels owned by each state: {pll_rst, domain_rst, ready, fault}.
  function automatic logic [3:0] out_dec(input state_t s);
    logic [3:0] o;
    case (s)
      S_RESET_PLL: o = 4'b1100;
      S_WAIT_LOCK: o = 4'b0100;
      S_STABLE:    o = 4'b0100;
      S_RUN:       o = 4'b0010;
      S_FAULT:     o = 4'b1101;
      default:     o = 4'b1100;
    endcase
    return o;
  endfunction

  assign lock_s      = lock_r;
  assign retry_inc_s = retry_r + RETRY_W'(1);
  assign state       = state_r;

  // Two-flop synchroniser bringing the asynchronous lock flag into refclk.
  always_ff @(posedge refclk) begin
    if (rst) begin
      meta_r <= 1'b0;
      lock_r <= 1'b0;
    end else begin
      meta_r <= pll_locked;
      lock_r <= meta_r;
    end
  end

  // Sequencing FSM; outputs are loaded together with the state they belong to.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_r       <= S_RESET_PLL;
      cnt_r         <= '0;
      retry_r       <= '0;
      lock_loss_cnt <= 8'd0;
      {pll_rst, domain_rst, ready, fault} <= out_dec(S_RESET_PLL);
    end else begin
      case (state_r)
        S_RESET_PLL: begin
          if (cnt_r == RST_LAST) begin
            state_r <= S_WAIT_LOCK;
            cnt_r   <= '0;
            {pll_rst, domain_rst, ready, fault} <= out_dec(S_WAIT_LOCK);
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        S_WAIT_LOCK: begin
          // A lock seen on the timeout cycle takes precedence over the retry.
          if (lock_s) begin
            state_r <= S_STABLE;
            cnt_r   <= '0;
            {pll_rst, domain_rst, ready, fault} <= out_dec(S_STABLE);
          end else if (cnt_r == TIMEOUT_LAST) begin
            cnt_r   <= '0;
            retry_r <= retry_inc_s;
            if (retry_inc_s == RETRY_MAX) begin
              state_r <= S_FAULT;
              {pll_rst, domain_rst, ready, fault} <= out_dec(S_FAULT);
            end else begin
              state_r <= S_RESET_PLL;
              {pll_rst, domain_rst, ready, fault} <= out_dec(S_RESET_PLL);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        S_STABLE: begin
          // A lock glitch restarts qualification without consuming a retry.
          if (!lock_s) begin
            state_r <= S_WAIT_LOCK;
            cnt_r   <= '0;
            {pll_rst, domain_rst, ready, fault} <= out_dec(S_WAIT_LOCK);
          end else if (cnt_r == STABLE_LAST) begin
            state_r <= S_RUN;
            cnt_r   <= '0;
            retry_r <= '0;
            {pll_rst, domain_rst, ready, fault} <= out_dec(S_RUN);
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        S_RUN: begin
          cnt_r <= '0;
          if (!lock_s) begin
            state_r <= S_RESET_PLL;
            if (lock_loss_cnt != 8'd255) begin
              lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end else begin
              lock_loss_cnt <= lock_loss_cnt;
            end
            {pll_rst, domain_rst, ready, fault} <= out_dec(S_RESET_PLL);
          end else begin
            state_r <= S_RUN;
          end
        end

        S_FAULT: begin
          cnt_r <= '0;
          if (retry_req) begin
            state_r <= S_RESET_PLL;
            retry_r <= '0;
            {pll_rst, domain_rst, ready, fault} <= out_dec(S_RESET_PLL);
          end else begin
            state_r <= S_FAULT;
          end
        end

        default: begin
          state_r <= S_RESET_PLL;
          cnt_r   <= '0;
          retry_r <= '0;
          {pll_rst, domain_rst, ready, fault} <= out_dec(S_RESET_PLL);
        end
      endcase
    end
  end

endmodule
